// File: rtl/dual_ram_ctrl.sv
// dual_ram_ctrl: zero-fills a dual-port RAM after reset, then shares its read
// and write ports between two req/gnt clients with per-port round-robin
// arbitration and write-wins same-address collision handling.
module dual_ram_ctrl #(
   parameter int unsigned RAM_WIDTH = 8,
   parameter int unsigned RAM_DEPTH = 16,
   parameter int unsigned ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 c0_req,
   input  logic                 c1_req,
   input  logic                 c0_we,
   input  logic                 c1_we,
   input  logic [ADDR_SIZE-1:0] c0_addr,
   input  logic [ADDR_SIZE-1:0] c1_addr,
   input  logic [RAM_WIDTH-1:0] c0_wdata,
   input  logic [RAM_WIDTH-1:0] c1_wdata,
   output logic                 c0_gnt,
   output logic                 c1_gnt,
   output logic                 c0_rvalid,
   output logic                 c1_rvalid,
   output logic [RAM_WIDTH-1:0] rdata,
   output logic                 busy,
   output logic                 ram_reset,
   output logic                 ram_read,
   output logic                 ram_write,
   output logic [ADDR_SIZE-1:0] ram_rd_addr,
   output logic [ADDR_SIZE-1:0] ram_wr_addr,
   output logic [RAM_WIDTH-1:0] ram_data_in,
   input  logic [RAM_WIDTH-1:0] ram_data_out
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);

   // State and internal bookkeeping
   logic [0:0]           state, state_nxt;
   logic [ADDR_SIZE-1:0] init_cnt, init_cnt_nxt;
   logic                 wr_last, wr_last_nxt;   // client granted last on write port
   logic                 rd_last, rd_last_nxt;   // client granted last on read port
   logic                 rd_tag, rd_tag_nxt;     // owner of the read in flight

   // Next values of registered outputs
   logic                 c0_gnt_nxt, c1_gnt_nxt;
   logic                 c0_rvalid_nxt, c1_rvalid_nxt;
   logic                 busy_nxt;
   logic                 ram_read_nxt, ram_write_nxt;
   logic [ADDR_SIZE-1:0] ram_rd_addr_nxt, ram_wr_addr_nxt;
   logic [RAM_WIDTH-1:0] ram_data_in_nxt;

   // Arbitration terms
   logic                 elig0, elig1;
   logic                 wcand0, wcand1, rcand0, rcand1;
   logic                 wr_any, rd_any, wr_sel, rd_sel;
   logic [ADDR_SIZE-1:0] wr_addr_sel, rd_addr_sel;
   logic [RAM_WIDTH-1:0] wr_data_sel;
   logic                 collide, rd_go;

   assign ram_reset = ~reset;
   assign rdata     = ram_data_out;

   // A client is not re-sampled during its own gnt cycle
   assign elig0  = c0_req & ~c0_gnt;
   assign elig1  = c1_req & ~c1_gnt;
   assign wcand0 = elig0 &  c0_we;
   assign wcand1 = elig1 &  c1_we;
   assign rcand0 = elig0 & ~c0_we;
   assign rcand1 = elig1 & ~c1_we;

   // Round-robin pick per port: on contention take the client not granted last
   assign wr_any = wcand0 | wcand1;
   assign rd_any = rcand0 | rcand1;
   assign wr_sel = (wcand0 & wcand1) ? ~wr_last : wcand1;
   assign rd_sel = (rcand0 & rcand1) ? ~rd_last : rcand1;

   assign wr_addr_sel = wr_sel ? c1_addr  : c0_addr;
   assign wr_data_sel = wr_sel ? c1_wdata : c0_wdata;
   assign rd_addr_sel = rd_sel ? c1_addr  : c0_addr;

   // Same-address read is held back a cycle so it observes the write
   assign collide = wr_any & rd_any & (wr_addr_sel == rd_addr_sel);
   assign rd_go   = rd_any & ~collide;

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         wr_last     <= 1'b1;
         rd_last     <= 1'b1;
         rd_tag      <= 1'b0;
         c0_gnt      <= 1'b0;
         c1_gnt      <= 1'b0;
         c0_rvalid   <= 1'b0;
         c1_rvalid   <= 1'b0;
         busy        <= 1'b1;
         ram_read    <= 1'b0;
         ram_write   <= 1'b0;
         ram_rd_addr <= '0;
         ram_wr_addr <= '0;
         ram_data_in <= '0;
      end else begin
         state       <= state_nxt;
         init_cnt    <= init_cnt_nxt;
         wr_last     <= wr_last_nxt;
         rd_last     <= rd_last_nxt;
         rd_tag      <= rd_tag_nxt;
         c0_gnt      <= c0_gnt_nxt;
         c1_gnt      <= c1_gnt_nxt;
         c0_rvalid   <= c0_rvalid_nxt;
         c1_rvalid   <= c1_rvalid_nxt;
         busy        <= busy_nxt;
         ram_read    <= ram_read_nxt;
         ram_write   <= ram_write_nxt;
         ram_rd_addr <= ram_rd_addr_nxt;
         ram_wr_addr <= ram_wr_addr_nxt;
         ram_data_in <= ram_data_in_nxt;
      end
   end

   // Next-state and next-output logic: init fill, then arbitrated access
   always_comb begin
      state_nxt       = state;
      init_cnt_nxt    = init_cnt;
      wr_last_nxt     = wr_last;
      rd_last_nxt     = rd_last;
      rd_tag_nxt      = rd_tag;
      c0_gnt_nxt      = 1'b0;
      c1_gnt_nxt      = 1'b0;
      busy_nxt        = busy;
      ram_read_nxt    = 1'b0;
      ram_write_nxt   = 1'b0;
      ram_rd_addr_nxt = ram_rd_addr;
      ram_wr_addr_nxt = ram_wr_addr;
      ram_data_in_nxt = ram_data_in;

      // rvalid follows the read strobe by one cycle, steered by the tag
      c0_rvalid_nxt   = ram_read & ~rd_tag;
      c1_rvalid_nxt   = ram_read &  rd_tag;

      case (state)
         ST_INIT: begin
            ram_write_nxt   = 1'b1;
            ram_wr_addr_nxt = init_cnt;
            ram_data_in_nxt = '0;
            init_cnt_nxt    = init_cnt + 1'b1;
            busy_nxt        = 1'b1;
            if (init_cnt == LAST_ADDR) begin
               state_nxt = ST_RUN;
               busy_nxt  = 1'b0;
            end
         end

         ST_RUN: begin
            busy_nxt = 1'b0;
            if (wr_any) begin
               ram_write_nxt   = 1'b1;
               ram_wr_addr_nxt = wr_addr_sel;
               ram_data_in_nxt = wr_data_sel;
               if (wr_sel) c1_gnt_nxt = 1'b1;
               else        c0_gnt_nxt = 1'b1;
               if (wcand0 & wcand1) wr_last_nxt = wr_sel;
            end
            if (rd_go) begin
               ram_read_nxt    = 1'b1;
               ram_rd_addr_nxt = rd_addr_sel;
               rd_tag_nxt      = rd_sel;
               if (rd_sel) c1_gnt_nxt = 1'b1;
               else        c0_gnt_nxt = 1'b1;
               if (rcand0 & rcand1) rd_last_nxt = rd_sel;
            end
         end

         default: begin
            state_nxt    = ST_INIT;
            init_cnt_nxt = '0;
            busy_nxt     = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_dual_ram_ctrl.sv
// Directed bench for dual_ram_ctrl with a behavioural dual-port RAM model.
module tb_dual_ram_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       c0_req, c1_req, c0_we, c1_we;
   logic [3:0] c0_addr, c1_addr;
   logic [7:0] c0_wdata, c1_wdata;
   logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [7:0] rdata;
   logic       busy, ram_reset, ram_read, ram_write;
   logic [3:0] ram_rd_addr, ram_wr_addr;
   logic [7:0] ram_data_in;
   logic [7:0] ram_data_out;

   logic [7:0] mem [16];
   logic       preload;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   dual_ram_ctrl dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
      .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
      .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
      .rdata(rdata), .busy(busy), .ram_reset(ram_reset),
      .ram_read(ram_read), .ram_write(ram_write),
      .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // RAM model: garbage preload so the zero fill is observable
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
         ram_data_out <= 8'hEE;
      end else begin
         if (ram_write) mem[ram_wr_addr] <= ram_data_in;
         if (ram_read)  ram_data_out <= mem[ram_rd_addr];
      end
   end

   task automatic set_c0(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
      c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wd;
   endtask

   task automatic set_c1(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
      c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wd;
   endtask

   task automatic test_reset;
      reset = 1'b0; preload = 1'b1;
      set_c0(1'b0, 1'b0, 4'h0, 8'h00);
      set_c1(1'b0, 1'b0, 4'h0, 8'h00);
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0b want 1", busy); end
      checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL rst_ram_write: got %0b want 0", ram_write); end
      checks++; if (ram_read !== 1'b0) begin errors++; $display("FAIL rst_ram_read: got %0b want 0", ram_read); end
      checks++; if (ram_reset !== 1'b1) begin errors++; $display("FAIL rst_ram_reset: got %0b want 1", ram_reset); end
      checks++; if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid} !== 4'b0) begin errors++; $display("FAIL rst_hs: got %b want 0000", {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid}); end
      reset = 1'b1; preload = 1'b0;
      set_c1(1'b1, 1'b0, 4'd7, 8'h00);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++; if (ram_write !== 1'b1 || ram_wr_addr !== 4'(i) || ram_data_in !== 8'h00) begin errors++; $display("FAIL init_wr[%0d]: got we=%0b a=%0d d=%h want we=1 a=%0d d=00", i, ram_write, ram_wr_addr, ram_data_in, i); end
         checks++; if (busy !== (i != 15)) begin errors++; $display("FAIL init_busy[%0d]: got %0b want %0b", i, busy, (i != 15)); end
         checks++; if (c1_gnt !== 1'b0 || ram_reset !== 1'b0) begin errors++; $display("FAIL init_gnt[%0d]: got gnt=%0b ram_reset=%0b want 0 0", i, c1_gnt, ram_reset); end
      end
      @(negedge clk);
      checks++; if (c1_gnt !== 1'b1 || ram_read !== 1'b1 || ram_rd_addr !== 4'd7) begin errors++; $display("FAIL init_rd_gnt: got gnt=%0b rd=%0b a=%0d want 1 1 7", c1_gnt, ram_read, ram_rd_addr); end
      checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL init_rd_nowr: got %0b want 0", ram_write); end
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++; if (c1_rvalid !== 1'b1 || rdata !== 8'h00) begin errors++; $display("FAIL init_rd_data: got rv=%0b d=%h want 1 00", c1_rvalid, rdata); end
      checks++; if (c0_rvalid !== 1'b0 || c1_gnt !== 1'b0) begin errors++; $display("FAIL init_rd_other: got rv0=%0b gnt1=%0b want 0 0", c0_rvalid, c1_gnt); end
   endtask

   task automatic test_write_contention;
      set_c0(1'b1, 1'b1, 4'd1, 8'h11);
      set_c1(1'b1, 1'b1, 4'd2, 8'h22);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (c0_gnt !== (i % 2 == 0) || c1_gnt !== (i % 2 == 1)) begin errors++; $display("FAIL wc_gnt[%0d]: got %0b%0b want %0b%0b", i, c0_gnt, c1_gnt, (i % 2 == 0), (i % 2 == 1)); end
         checks++; if (ram_write !== 1'b1 || ram_wr_addr !== ((i % 2 == 0) ? 4'd1 : 4'd2) || ram_data_in !== ((i % 2 == 0) ? 8'h11 : 8'h22)) begin errors++; $display("FAIL wc_cmd[%0d]: got we=%0b a=%0d d=%h", i, ram_write, ram_wr_addr, ram_data_in); end
      end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++; if (ram_write !== 1'b0 || c0_gnt !== 1'b0 || c1_gnt !== 1'b0) begin errors++; $display("FAIL wc_idle: got we=%0b gnt=%0b%0b want 0 00", ram_write, c0_gnt, c1_gnt); end
      checks++; if (mem[1] !== 8'h11 || mem[2] !== 8'h22) begin errors++; $display("FAIL wc_mem: got %h %h want 11 22", mem[1], mem[2]); end
   endtask

   task automatic test_single_client;
      set_c0(1'b1, 1'b1, 4'd3, 8'hA5);
      @(negedge clk);
      checks++; if (c0_gnt !== 1'b1 || ram_write !== 1'b1 || ram_wr_addr !== 4'd3 || ram_data_in !== 8'hA5) begin errors++; $display("FAIL sc_wr: got gnt=%0b we=%0b a=%0d d=%h want 1 1 3 a5", c0_gnt, ram_write, ram_wr_addr, ram_data_in); end
      set_c0(1'b1, 1'b0, 4'd3, 8'h00);
      @(negedge clk);
      checks++; if (c0_gnt !== 1'b0 || ram_read !== 1'b0 || ram_write !== 1'b0) begin errors++; $display("FAIL sc_gap: got gnt=%0b rd=%0b we=%0b want 0 0 0", c0_gnt, ram_read, ram_write); end
      @(negedge clk);
      checks++; if (c0_gnt !== 1'b1 || ram_read !== 1'b1 || ram_rd_addr !== 4'd3) begin errors++; $display("FAIL sc_rd: got gnt=%0b rd=%0b a=%0d want 1 1 3", c0_gnt, ram_read, ram_rd_addr); end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++; if (c0_rvalid !== 1'b1 || rdata !== 8'hA5) begin errors++; $display("FAIL sc_data: got rv=%0b d=%h want 1 a5", c0_rvalid, rdata); end
      checks++; if (c1_rvalid !== 1'b0) begin errors++; $display("FAIL sc_c1rv: got %0b want 0", c1_rvalid); end
   endtask

   task automatic test_collision;
      set_c0(1'b1, 1'b1, 4'd9, 8'h5A);
      set_c1(1'b1, 1'b0, 4'd9, 8'h00);
      @(negedge clk);
      checks++; if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0) begin errors++; $display("FAIL col_first: got gnt=%0b%0b want 10", c0_gnt, c1_gnt); end
      checks++; if (ram_write !== 1'b1 || ram_wr_addr !== 4'd9 || ram_read !== 1'b0) begin errors++; $display("FAIL col_cmd: got we=%0b a=%0d rd=%0b want 1 9 0", ram_write, ram_wr_addr, ram_read); end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++; if (c1_gnt !== 1'b1 || c0_gnt !== 1'b0 || ram_read !== 1'b1 || ram_rd_addr !== 4'd9) begin errors++; $display("FAIL col_second: got gnt=%0b%0b rd=%0b a=%0d want 01 1 9", c0_gnt, c1_gnt, ram_read, ram_rd_addr); end
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++; if (c1_rvalid !== 1'b1 || c0_rvalid !== 1'b0 || rdata !== 8'h5A) begin errors++; $display("FAIL col_data: got rv=%0b%0b d=%h want 01 5a", c0_rvalid, c1_rvalid, rdata); end
   endtask

   task automatic test_parallel;
      set_c0(1'b1, 1'b0, 4'd3, 8'h00);
      set_c1(1'b1, 1'b1, 4'd4, 8'h77);
      @(negedge clk);
      checks++; if (c0_gnt !== 1'b1 || c1_gnt !== 1'b1) begin errors++; $display("FAIL par_gnt: got %0b%0b want 11", c0_gnt, c1_gnt); end
      checks++; if (ram_read !== 1'b1 || ram_rd_addr !== 4'd3 || ram_write !== 1'b1 || ram_wr_addr !== 4'd4 || ram_data_in !== 8'h77) begin errors++; $display("FAIL par_cmd: got rd=%0b ra=%0d we=%0b wa=%0d d=%h", ram_read, ram_rd_addr, ram_write, ram_wr_addr, ram_data_in); end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++; if (c0_rvalid !== 1'b1 || c1_rvalid !== 1'b0 || rdata !== 8'hA5) begin errors++; $display("FAIL par_data: got rv=%0b%0b d=%h want 10 a5", c0_rvalid, c1_rvalid, rdata); end
      checks++; if (mem[4] !== 8'h77) begin errors++; $display("FAIL par_mem: got %h want 77", mem[4]); end
   endtask

   task automatic test_mid_read_reset;
      set_c1(1'b1, 1'b0, 4'd2, 8'h00);
      @(negedge clk);
      checks++; if (ram_read !== 1'b1 || c1_gnt !== 1'b1) begin errors++; $display("FAIL mr_pre: got rd=%0b gnt=%0b want 1 1", ram_read, c1_gnt); end
      reset = 1'b0;
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      #1;
      checks++; if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, ram_read, ram_write} !== 6'b0) begin errors++; $display("FAIL mr_ctl: got %b want 000000", {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, ram_read, ram_write}); end
      checks++; if (ram_rd_addr !== 4'd0 || ram_wr_addr !== 4'd0 || ram_data_in !== 8'h00) begin errors++; $display("FAIL mr_bus: got ra=%0d wa=%0d d=%h want 0 0 00", ram_rd_addr, ram_wr_addr, ram_data_in); end
      checks++; if (busy !== 1'b1 || ram_reset !== 1'b1) begin errors++; $display("FAIL mr_busy: got busy=%0b ram_reset=%0b want 1 1", busy, ram_reset); end
      @(negedge clk);
      checks++; if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0) begin errors++; $display("FAIL mr_rvalid: got %0b%0b want 00", c0_rvalid, c1_rvalid); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (ram_write !== 1'b1 || ram_wr_addr !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL mr_init0: got we=%0b a=%0d busy=%0b want 1 0 1", ram_write, ram_wr_addr, busy); end
      @(negedge clk);
      checks++; if (ram_write !== 1'b1 || ram_wr_addr !== 4'd1 || c1_rvalid !== 1'b0) begin errors++; $display("FAIL mr_init1: got we=%0b a=%0d rv=%0b want 1 1 0", ram_write, ram_wr_addr, c1_rvalid); end
   endtask

   initial begin
      test_reset();
      test_write_contention();
      test_single_client();
      test_collision();
      test_parallel();
      test_mid_read_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
